edge_scanner: RTL and testbench

- Parametrised successor to the frame-buffer edge finder; sits between the binary-mask frame buffer (BRAM read port) and the corner/crop logic.
- On a start pulse it fetches the row and column through a given centre point, then searches outward from the centre in four directions.
- An edge is a run of RUN_LEN foreground pixels followed by a run of RUN_LEN background pixels.
- Adds a configurable run length, configurable BRAM read latency, a start/busy/done handshake, per-edge found flags and centre range checking.

---
 rtl/edge_scanner.sv | 233 +++++++++++++++++++++++
 tb/tb_edge_scanner.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_scanner.sv
// rtl/edge_scanner.sv - binary-mask edge finder: fetches the centre row/column, then searches outward in four directions
module edge_scanner #(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int RUN_LEN      = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic [$clog2(WIDTH)-1:0]          x_center_in,
  input  logic [$clog2(HEIGHT)-1:0]         y_center_in,
  input  logic                              pixel_data_in,
  output logic [$clog2(WIDTH*HEIGHT)-1:0]   addr_out,
  output logic                              addr_valid_out,
  output logic                              busy_out,
  output logic                              done_out,
  output logic                              err_out,
  output logic [3:0]                        found_out,
  output logic [$clog2(WIDTH)-1:0]          right_edge_out,
  output logic [$clog2(WIDTH)-1:0]          left_edge_out,
  output logic [$clog2(HEIGHT)-1:0]         top_edge_out,
  output logic [$clog2(HEIGHT)-1:0]         bot_edge_out
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int CW = (XW > YW) ? XW : YW;
  localparam int PW = CW + 1;

  typedef enum logic [3:0] {
    IDLE, FETCH_ROW, FETCH_COL, DRAIN, S_RIGHT, S_LEFT, S_DOWN, S_UP, DONE
  } state_t;

  state_t                  state;
  logic [XW-1:0]           x_lat;
  logic [YW-1:0]           y_lat;
  logic [CW-1:0]           cnt;
  logic signed [PW-1:0]    pos;
  logic [WIDTH-1:0]        row_buf;
  logic [HEIGHT-1:0]       col_buf;

  logic [READ_LATENCY-1:0] d_valid;
  logic [READ_LATENCY-1:0] d_col;
  logic [CW-1:0]           d_idx [READ_LATENCY];

  logic                    on_col;
  logic                    fwd;
  logic                    hit;
  logic                    at_bound;
  int                      pi;
  int                      fg;
  int                      bg;
  logic [AW-1:0]           row_base;

  // Anything outside the fetched line reads as background.
  function automatic logic line_at(input logic [WIDTH-1:0] rb, input logic [HEIGHT-1:0] cb,
                                   input logic col, input int i);
    logic v;
    v = 1'b0;
    if (col) begin
      if (i >= 0 && i < HEIGHT) v = cb[i[YW-1:0]];
    end else begin
      if (i >= 0 && i < WIDTH) v = rb[i[XW-1:0]];
    end
    return v;
  endfunction

  assign row_base = AW'(y_center_in) * AW'(WIDTH);

  always_comb begin
    on_col   = (state == S_DOWN) || (state == S_UP);
    fwd      = (state == S_RIGHT) || (state == S_DOWN);
    pi       = int'(pos);
    fg       = 0;
    bg       = 0;
    hit      = 1'b1;
    for (int k = 0; k < RUN_LEN; k++) begin
      fg = fwd ? pi - k : pi + k;
      bg = fwd ? pi + 1 + k : pi - 1 - k;
      if (!line_at(row_buf, col_buf, on_col, fg) || line_at(row_buf, col_buf, on_col, bg))
        hit = 1'b0;
    end
    if (fwd) at_bound = (pi == (on_col ? HEIGHT - 1 : WIDTH - 1));
    else     at_bound = (pi == 0);
  end

  // Tag pipeline tracks which line/index each outstanding read belongs to.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      d_valid <= '0;
      d_col   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d_idx[i] <= '0;
      row_buf <= '0;
      col_buf <= '0;
    end else begin
      d_valid[0] <= addr_valid_out;
      d_col[0]   <= (state == FETCH_COL);
      d_idx[0]   <= cnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        d_valid[i] <= d_valid[i-1];
        d_col[i]   <= d_col[i-1];
        d_idx[i]   <= d_idx[i-1];
      end
      if (d_valid[READ_LATENCY-1]) begin
        if (d_col[READ_LATENCY-1]) col_buf[d_idx[READ_LATENCY-1][YW-1:0]] <= pixel_data_in;
        else                       row_buf[d_idx[READ_LATENCY-1][XW-1:0]] <= pixel_data_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      x_lat          <= '0;
      y_lat          <= '0;
      cnt            <= '0;
      pos            <= '0;
      addr_out       <= '0;
      addr_valid_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      err_out        <= 1'b0;
      found_out      <= '0;
      right_edge_out <= '0;
      left_edge_out  <= '0;
      top_edge_out   <= '0;
      bot_edge_out   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_out <= 1'b0;
          state    <= IDLE;
          if (start_in) begin
            x_lat     <= x_center_in;
            y_lat     <= y_center_in;
            found_out <= '0;
            if (int'(x_center_in) >= WIDTH || int'(y_center_in) >= HEIGHT) begin
              err_out        <= 1'b1;
              done_out       <= 1'b1;
              busy_out       <= 1'b0;
              right_edge_out <= '0;
              left_edge_out  <= '0;
              top_edge_out   <= '0;
              bot_edge_out   <= '0;
              state          <= DONE;
            end else begin
              err_out        <= 1'b0;
              busy_out       <= 1'b1;
              addr_out       <= row_base;
              addr_valid_out <= 1'b1;
              cnt            <= '0;
              state          <= FETCH_ROW;
            end
          end
        end
        FETCH_ROW: begin
          if (cnt == CW'(WIDTH - 1)) begin
            cnt      <= '0;
            addr_out <= AW'(x_lat);
            state    <= FETCH_COL;
          end else begin
            cnt      <= cnt + 1'b1;
            addr_out <= addr_out + 1'b1;
          end
        end
        FETCH_COL: begin
          if (cnt == CW'(HEIGHT - 1)) begin
            cnt            <= '0;
            addr_valid_out <= 1'b0;
            state          <= DRAIN;
          end else begin
            cnt      <= cnt + 1'b1;
            addr_out <= addr_out + AW'(WIDTH);
          end
        end
        DRAIN: begin
          if (cnt == CW'(READ_LATENCY - 1)) begin
            cnt   <= '0;
            pos   <= PW'(x_lat);
            state <= S_RIGHT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RIGHT: begin
          if (hit || at_bound) begin
            right_edge_out <= hit ? pos[XW-1:0] : XW'(WIDTH - 1);
            found_out[0]   <= hit;
            pos            <= PW'(x_lat);
            state          <= S_LEFT;
          end else begin
            pos <= pos + PW'(1);
          end
        end
        S_LEFT: begin
          if (hit || at_bound) begin
            left_edge_out <= hit ? pos[XW-1:0] : '0;
            found_out[1]  <= hit;
            pos           <= PW'(y_lat);
            state         <= S_DOWN;
          end else begin
            pos <= pos - PW'(1);
          end
        end
        S_DOWN: begin
          if (hit || at_bound) begin
            bot_edge_out <= hit ? pos[YW-1:0] : YW'(HEIGHT - 1);
            found_out[3] <= hit;
            pos          <= PW'(y_lat);
            state        <= S_UP;
          end else begin
            pos <= pos + PW'(1);
          end
        end
        S_UP: begin
          if (hit || at_bound) begin
            top_edge_out <= hit ? pos[YW-1:0] : '0;
            found_out[2] <= hit;
            busy_out     <= 1'b0;
            done_out     <= 1'b1;
            state        <= DONE;
          end else begin
            pos <= pos - PW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_scanner.sv
// tb/tb_edge_scanner.sv - self-checking bench for edge_scanner against a frame-level reference model
module tb_edge_scanner;

  localparam int W   = 32;
  localparam int H   = 24;
  localparam int RL  = 4;
  localparam int LAT = 2;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int AW  = $clog2(W * H);
  localparam int MAX_LAT = (W + H + LAT) + (W + H + 4) + 1;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic [XW-1:0]     x_center_in;
  logic [YW-1:0]     y_center_in;
  logic              pixel_data_in;
  logic [AW-1:0]     addr_out;
  logic              addr_valid_out;
  logic              busy_out;
  logic              done_out;
  logic              err_out;
  logic [3:0]        found_out;
  logic [XW-1:0]     right_edge_out;
  logic [XW-1:0]     left_edge_out;
  logic [YW-1:0]     top_edge_out;
  logic [YW-1:0]     bot_edge_out;

  edge_scanner #(.WIDTH(W), .HEIGHT(H), .RUN_LEN(RL), .READ_LATENCY(LAT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .x_center_in(x_center_in), .y_center_in(y_center_in), .pixel_data_in(pixel_data_in),
    .addr_out(addr_out), .addr_valid_out(addr_valid_out), .busy_out(busy_out),
    .done_out(done_out), .err_out(err_out), .found_out(found_out),
    .right_edge_out(right_edge_out), .left_edge_out(left_edge_out),
    .top_edge_out(top_edge_out), .bot_edge_out(bot_edge_out)
  );

  always #5 clk_in = ~clk_in;

  // Frame buffer with a fixed read latency of LAT cycles.
  logic           mem [W*H];
  logic [LAT-1:0] rd_pipe = '0;
  always @(posedge clk_in) rd_pipe <= {rd_pipe[LAT-2:0], mem[int'(addr_out)]};
  assign pixel_data_in = rd_pipe[LAT-1];

  int compared   = 0;
  int mismatched = 0;
  int addr_q[$];
  int done_pulses = 0;

  always @(negedge clk_in) begin
    if (addr_valid_out) addr_q.push_back(int'(addr_out));
    if (done_out) done_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < W*H; i++) mem[i] = 1'b0;
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) mem[yy*W + xx] = 1'b1;
  endtask

  function automatic logic pix(input int xx, input int yy);
    if (xx < 0 || xx >= W || yy < 0 || yy >= H) return 1'b0;
    return mem[yy*W + xx];
  endfunction

  // Edge at p along a line walking in direction dir: RL foreground behind, RL background ahead.
  function automatic logic edge_at(input bit vert, input int line, input int p, input int dir);
    for (int k = 0; k < RL; k++) begin
      int a, b;
      logic fa, fb;
      a  = p - dir*k;
      b  = p + dir*(k + 1);
      fa = vert ? pix(line, a) : pix(a, line);
      fb = vert ? pix(line, b) : pix(b, line);
      if (!fa || fb) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model(input int x, input int y, output int r, output int l, output int t,
                       output int b, output logic [3:0] f, output logic e);
    f = 4'b0000;
    if (x >= W || y >= H) begin
      e = 1'b1; r = 0; l = 0; t = 0; b = 0;
    end else begin
      e = 1'b0; r = W - 1; l = 0; t = 0; b = H - 1;
      for (int p = x; p < W; p++)   if (edge_at(1'b0, y, p, 1))  begin r = p; f[0] = 1'b1; break; end
      for (int p = x; p >= 0; p--)  if (edge_at(1'b0, y, p, -1)) begin l = p; f[1] = 1'b1; break; end
      for (int p = y; p < H; p++)   if (edge_at(1'b1, x, p, 1))  begin b = p; f[3] = 1'b1; break; end
      for (int p = y; p >= 0; p--)  if (edge_at(1'b1, x, p, -1)) begin t = p; f[2] = 1'b1; break; end
    end
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 1;
    while (!done_out && cycles < 3*(W + H)) begin
      @(negedge clk_in);
      cycles++;
    end
    check({tag, " done seen"}, done_out, 1);
  endtask

  task automatic check_results(input string tag, input int x, input int y);
    int r, l, t, b;
    logic [3:0] f;
    logic e;
    model(x, y, r, l, t, b, f, e);
    check({tag, " err"},   err_out, e);
    check({tag, " found"}, found_out, f);
    check({tag, " right"}, right_edge_out, r);
    check({tag, " left"},  left_edge_out, l);
    check({tag, " top"},   top_edge_out, t);
    check({tag, " bot"},   bot_edge_out, b);
    check({tag, " busy at done"}, busy_out, 0);
  endtask

  task automatic run_scan(input string tag, input int x, input int y, output int cycles);
    addr_q.delete();
    @(negedge clk_in);
    x_center_in = XW'(x);
    y_center_in = YW'(y);
    start_in    = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done(tag, cycles);
    check_results(tag, x, y);
    @(negedge clk_in);
    check({tag, " done one cycle"}, done_out, 0);
  endtask

  initial begin
    int cyc, bad, snap;
    rst_in = 1'b1; start_in = 1'b0; x_center_in = '0; y_center_in = '0;
    clear_frame();
    repeat (3) @(negedge clk_in);
    check("reset addr", addr_out, 0);
    check("reset ctl", {addr_valid_out, busy_out, done_out, err_out}, 0);
    check("reset found", found_out, 0);
    check("reset edges", {right_edge_out, left_edge_out, top_edge_out, bot_edge_out}, 0);
    rst_in = 1'b0;

    // Case 1: centred rectangle, plus full address sequence.
    rect(10, 20, 5, 15);
    run_scan("c1", 15, 10, cyc);
    check("c1 found const", found_out, 4'b1111);
    check("c1 edges const", {right_edge_out, left_edge_out, top_edge_out, bot_edge_out},
          {5'd20, 5'd10, 5'd5, 5'd15});
    check("c1 latency", cyc <= MAX_LAT, 1);
    check("c1 addr count", addr_q.size(), W + H);
    bad = 0;
    for (int i = 0; i < addr_q.size(); i++)
      if (addr_q[i] != ((i < W) ? 10*W + i : (i - W)*W + 15)) bad++;
    check("c1 addr seq errors", bad, 0);

    // Case 2: object touching the right and top borders.
    clear_frame(); rect(10, 31, 0, 15);
    run_scan("c2", 20, 8, cyc);
    check("c2 right/top", {right_edge_out, top_edge_out}, {5'd31, 5'd0});

    // Case 3: one-pixel hole breaks the right run.
    clear_frame(); rect(10, 20, 5, 15); mem[10*W + 18] = 1'b0;
    run_scan("c3", 12, 10, cyc);
    check("c3 right missing", {found_out[0], right_edge_out}, {1'b0, 5'd31});

    // Case 4: empty frame, full-length search.
    clear_frame();
    run_scan("c4", 5, 5, cyc);
    check("c4 latency", cyc <= MAX_LAT, 1);

    // Case 5: centre out of range, immediate error.
    run_scan("c5", 3, 28, cyc);
    check("c5 latency", cyc, 1);
    check("c5 no reads", addr_q.size(), 0);

    // Case 6a: start during FETCH_COL is ignored.
    clear_frame(); rect(10, 20, 5, 15);
    @(negedge clk_in);
    x_center_in = 5'd15; y_center_in = 5'd10; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (39) @(negedge clk_in);
    x_center_in = 5'd3; y_center_in = 5'd3; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    wait_done("c6a", cyc);
    check_results("c6a", 15, 10);
    @(negedge clk_in);

    // Case 6b: reset while searching left aborts without done.
    @(negedge clk_in);
    x_center_in = 5'd15; y_center_in = 5'd10; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (66) @(negedge clk_in);
    check("c6b busy before reset", busy_out, 1);
    snap = done_pulses;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("c6b reset ctl", {addr_valid_out, busy_out, done_out, err_out}, 0);
    check("c6b reset outs", {found_out, right_edge_out, left_edge_out, top_edge_out, bot_edge_out}, 0);
    repeat (3*(W + H)) @(negedge clk_in);
    check("c6b no done after abort", done_pulses, snap);
    run_scan("c6c", 15, 10, cyc);

    // Randomised frames: rectangle plus sparse noise, occasional bad centre.
    for (int trial = 0; trial < 10; trial++) begin
      int x0, x1, y0, y1, cx, cy;
      string tg;
      clear_frame();
      x0 = $urandom_range(0, W - 1); x1 = $urandom_range(x0, W - 1);
      y0 = $urandom_range(0, H - 1); y1 = $urandom_range(y0, H - 1);
      rect(x0, x1, y0, y1);
      if (trial % 2 == 1)
        for (int i = 0; i < W*H; i++) if ($urandom_range(0, 15) == 0) mem[i] = 1'b1;
      cx = $urandom_range(x0, x1);
      cy = (trial % 5 == 4) ? $urandom_range(H, 31) : $urandom_range(y0, y1);
      tg = $sformatf("rnd%0d", trial);
      run_scan(tg, cx, cy, cyc);
      check({tg, " latency"}, cyc <= MAX_LAT, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
